enemy_spawn_control: RTL and testbench

//  Parametrised, sequential successor to the static plane-amount decoder. It keeps
//  a registered visibility mask of N_SLOTS enemy-plane slots. Free slots are

---
 rtl/enemy_spawn_control_pkg.sv | 25 ++
 rtl/enemy_spawn_control_slot_pick.sv | 29 ++
 rtl/enemy_spawn_control.sv | 143 ++++++++++++++
 tb/tb_enemy_spawn_control.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_spawn_control_pkg.sv
// Shared types and helpers for the enemy spawn controller.
package enemy_spawn_control_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_e;

  localparam int unsigned DEF_N_SLOTS = 10;
  localparam int unsigned DEF_AMT_W   = 4;
  localparam int unsigned MAX_SLOTS   = 16;
  localparam int unsigned CNT_W       = 5;

  // Population count over the widest supported slot mask.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_SLOTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_SLOTS); i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/enemy_spawn_control_slot_pick.sv
// Combinational slot selection: lowest free slot, highest occupied slot,
// free flag and occupancy count of a visibility mask.
module enemy_spawn_control_slot_pick
  import enemy_spawn_control_pkg::*;
#(
  parameter int unsigned N_SLOTS = DEF_N_SLOTS,
  parameter int unsigned AMT_W   = DEF_AMT_W
) (
  input  logic [N_SLOTS-1:0] i_vis,
  output logic [N_SLOTS-1:0] o_low_zero,
  output logic [N_SLOTS-1:0] o_high_one,
  output logic               o_any_free,
  output logic [AMT_W-1:0]   o_count
);

  // Adding one ripples through the trailing ones and lands on the first zero.
  assign o_low_zero = ~i_vis & (i_vis + N_SLOTS'(1));
  assign o_any_free = ~&i_vis;
  assign o_count    = AMT_W'(popcount(MAX_SLOTS'(i_vis)));

  // Highest set bit as a one-hot; later iterations override earlier ones.
  always_comb begin
    o_high_one = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (i_vis[i]) o_high_one = N_SLOTS'(1) << i;
    end
  end

endmodule

// File: rtl/enemy_spawn_control.sv
// Enemy spawn controller: FSM, spawn timer and registered visibility mask.
// Optional feature macro: RESPAWN_HOLDOFF_EN (kills reload the spawn timer).
module enemy_spawn_control
  import enemy_spawn_control_pkg::*;
#(
  parameter int unsigned N_SLOTS     = DEF_N_SLOTS,
  parameter int unsigned AMT_W       = DEF_AMT_W,
  parameter int unsigned SPAWN_TICKS = 60,
  parameter int unsigned TMR_W       = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [AMT_W-1:0]   target_amount,
  input  logic [N_SLOTS-1:0] kill,
  output logic [N_SLOTS-1:0] vis,
  output logic [AMT_W-1:0]   active_count,
  output logic               spawn_pulse,
  output logic               wave_clear
);

  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(SPAWN_TICKS - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [N_SLOTS-1:0] r_vis;
  logic [N_SLOTS-1:0] w_vis_nxt;
  logic [AMT_W-1:0]   r_count;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic               r_spawn_pulse;
  logic               w_spawn_nxt;
  logic               r_wave_clear;
  logic               w_wave_nxt;

  logic [N_SLOTS-1:0] w_low_zero;
  logic [N_SLOTS-1:0] w_high_one;
  logic               w_any_free;
  logic [AMT_W-1:0]   w_cnt;
  logic [AMT_W-1:0]   w_tgt;
  logic               w_go;
  logic               w_spawn;
  logic               w_retire;
  logic               w_kill_hit;

  enemy_spawn_control_slot_pick #(
    .N_SLOTS (N_SLOTS),
    .AMT_W   (AMT_W)
  ) u_slot_pick (
    .i_vis      (r_vis),
    .o_low_zero (w_low_zero),
    .o_high_one (w_high_one),
    .o_any_free (w_any_free),
    .o_count    (w_cnt)
  );

  // Requested amount clamped to 1..N_SLOTS, sampled live.
  always_comb begin
    if (target_amount == '0)                   w_tgt = AMT_W'(1);
    else if (target_amount > AMT_W'(N_SLOTS))  w_tgt = AMT_W'(N_SLOTS);
    else                                       w_tgt = target_amount;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; stop overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start)  w_state_nxt = S_RUN;
        S_RUN:    if (pause)  w_state_nxt = S_PAUSED;
        S_PAUSED: if (!pause) w_state_nxt = S_RUN;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_go       = (r_state == S_RUN) && !pause && tick;
  assign w_spawn    = w_go && (r_timer == '0) && (w_cnt < w_tgt) && w_any_free;
  assign w_retire   = w_go && (w_cnt > w_tgt);
  assign w_kill_hit = |(kill & r_vis);

  // Mask, timer and pulse next values; kills are applied after spawn/retire.
  always_comb begin
    w_vis_nxt   = r_vis;
    w_timer_nxt = r_timer;
    w_spawn_nxt = 1'b0;
    w_wave_nxt  = 1'b0;
    if (stop) begin
      w_vis_nxt   = '0;
      w_timer_nxt = RELOAD;
    end else if (r_state == S_IDLE) begin
      if (start) w_timer_nxt = '0;
    end else begin
      if (w_spawn)       w_vis_nxt = r_vis | w_low_zero;
      else if (w_retire) w_vis_nxt = r_vis & ~w_high_one;
      w_vis_nxt = w_vis_nxt & ~kill;
      if (w_go) begin
        if (r_timer != '0) w_timer_nxt = r_timer - TMR_W'(1);
        else if (w_spawn)  w_timer_nxt = RELOAD;
      end
`ifdef RESPAWN_HOLDOFF_EN
      if (w_kill_hit) w_timer_nxt = RELOAD;
`else
`endif
      w_spawn_nxt = w_spawn;
      w_wave_nxt  = w_kill_hit && (w_vis_nxt == '0);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vis         <= '0;
      r_count       <= '0;
      r_timer       <= RELOAD;
      r_spawn_pulse <= 1'b0;
      r_wave_clear  <= 1'b0;
    end else begin
      r_vis         <= w_vis_nxt;
      r_count       <= AMT_W'(popcount(MAX_SLOTS'(w_vis_nxt)));
      r_timer       <= w_timer_nxt;
      r_spawn_pulse <= w_spawn_nxt;
      r_wave_clear  <= w_wave_nxt;
    end
  end

  assign vis          = r_vis;
  assign active_count = r_count;
  assign spawn_pulse  = r_spawn_pulse;
  assign wave_clear   = r_wave_clear;

endmodule

// File: tb/tb_enemy_spawn_control.sv
// Directed self-checking bench for enemy_spawn_control (N_SLOTS=10, SPAWN_TICKS=4).
module tb_enemy_spawn_control;

  logic       clk;
  logic       resetn;
  logic       tick;
  logic       start;
  logic       pause;
  logic       stop;
  logic [3:0] target_amount;
  logic [9:0] kill;
  logic [9:0] vis;
  logic [3:0] active_count;
  logic       spawn_pulse;
  logic       wave_clear;

  int checks;
  int failures;

  enemy_spawn_control #(
    .N_SLOTS     (10),
    .AMT_W       (4),
    .SPAWN_TICKS (4),
    .TMR_W       (8)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .tick          (tick),
    .start         (start),
    .pause         (pause),
    .stop          (stop),
    .target_amount (target_amount),
    .kill          (kill),
    .vis           (vis),
    .active_count  (active_count),
    .spawn_pulse   (spawn_pulse),
    .wave_clear    (wave_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick = 0; start = 0; pause = 0; stop = 0;
    target_amount = 4'd0; kill = '0;
    step(); step();
    checks++;
    if (vis !== 10'h000 || active_count !== 4'd0 || spawn_pulse !== 1'b0 || wave_clear !== 1'b0) begin
      failures++;
      $display("FAIL reset vis=%h count=%0d sp=%b wc=%b required all zero", vis, active_count, spawn_pulse, wave_clear);
    end
    resetn = 1'b1;
    step();
    do_tick();
    checks++;
    if (vis !== 10'h000) begin
      failures++;
      $display("FAIL idle_no_spawn vis=%h required 000", vis);
    end
  endtask

  task automatic test_ramp();
    logic [9:0] e;
    int sp_seen;
    sp_seen = 0;
    target_amount = 4'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      do_tick();
      e = (k < 5) ? 10'h001 : (k < 9) ? 10'h003 : 10'h007;
      checks++;
      if (vis !== e || active_count !== 4'($countones(e))) begin
        failures++;
        $display("FAIL ramp_vis tick=%0d vis=%h count=%0d required %h/%0d", k, vis, active_count, e, $countones(e));
      end
      checks++;
      if (spawn_pulse !== (k == 1 || k == 5 || k == 9)) begin
        failures++;
        $display("FAIL ramp_pulse tick=%0d sp=%b", k, spawn_pulse);
      end
      if (spawn_pulse === 1'b1) sp_seen++;
    end
    checks++;
    if (sp_seen != 3) begin
      failures++;
      $display("FAIL ramp_pulse_count got=%0d required 3", sp_seen);
    end
  endtask

  task automatic test_kill_refill();
    kill = 10'b0000000010; step(); kill = '0;
    checks++;
    if (vis !== 10'h005 || active_count !== 4'd2 || wave_clear !== 1'b0) begin
      failures++;
      $display("FAIL kill_one vis=%h count=%0d wc=%b required 005/2/0", vis, active_count, wave_clear);
    end
    do_tick();
    checks++;
    if (vis !== 10'h007 || spawn_pulse !== 1'b1) begin
      failures++;
      $display("FAIL refill vis=%h sp=%b required 007/1", vis, spawn_pulse);
    end
  endtask

  task automatic test_clamp();
    logic [9:0] e;
    int n;
    target_amount = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      e = (k == 1) ? 10'h003 : 10'h001;
      checks++;
      if (vis !== e) begin
        failures++;
        $display("FAIL clamp_zero tick=%0d vis=%h required %h", k, vis, e);
      end
    end
    target_amount = 4'd15;
    for (int k = 1; k <= 40; k++) begin
      do_tick();
      n = 2 + (k - 1) / 4;
      if (n > 10) n = 10;
      e = 10'((1 << n) - 1);
      checks++;
      if (vis !== e || active_count !== 4'(n)) begin
        failures++;
        $display("FAIL clamp_15 tick=%0d vis=%h count=%0d required %h/%0d", k, vis, active_count, e, n);
      end
    end
    target_amount = 4'd11;
    do_tick();
    checks++;
    if (vis !== 10'h3FF || active_count !== 4'd10) begin
      failures++;
      $display("FAIL clamp_11 vis=%h count=%0d required 3ff/10", vis, active_count);
    end
    target_amount = 4'd5;
    for (int j = 1; j <= 5; j++) begin
      do_tick();
      e = 10'((1 << (10 - j)) - 1);
      checks++;
      if (vis !== e || spawn_pulse !== 1'b0) begin
        failures++;
        $display("FAIL retire_5 step=%0d vis=%h sp=%b required %h/0", j, vis, spawn_pulse, e);
      end
    end
    target_amount = 4'd2;
    for (int j = 1; j <= 4; j++) begin
      do_tick();
      n = (j < 3) ? 5 - j : 2;
      e = 10'((1 << n) - 1);
      checks++;
      if (vis !== e || active_count !== 4'(n)) begin
        failures++;
        $display("FAIL retire_2 step=%0d vis=%h count=%0d required %h/%0d", j, vis, active_count, e, n);
      end
    end
  endtask

  task automatic test_wave_clear();
    logic [9:0] e;
    target_amount = 4'd1;
    do_tick();
    checks++;
    if (vis !== 10'h001) begin
      failures++;
      $display("FAIL wave_setup vis=%h required 001", vis);
    end
    kill = 10'b1; do_tick(); kill = '0;
    checks++;
    if (vis !== 10'h000 || active_count !== 4'd0 || wave_clear !== 1'b1 || spawn_pulse !== 1'b0) begin
      failures++;
      $display("FAIL wave_clear vis=%h count=%0d wc=%b sp=%b required 000/0/1/0", vis, active_count, wave_clear, spawn_pulse);
    end
    step();
    checks++;
    if (wave_clear !== 1'b0) begin
      failures++;
      $display("FAIL wave_single wc=%b required 0", wave_clear);
    end
    kill = 10'b1; do_tick(); kill = '0;
    checks++;
    if (vis !== 10'h000 || spawn_pulse !== 1'b1 || wave_clear !== 1'b0) begin
      failures++;
      $display("FAIL kill_wins vis=%h sp=%b wc=%b required 000/1/0", vis, spawn_pulse, wave_clear);
    end
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      e = (k < 4) ? 10'h000 : 10'h001;
      checks++;
      if (vis !== e) begin
        failures++;
        $display("FAIL after_kill_wins tick=%0d vis=%h required %h", k, vis, e);
      end
    end
    target_amount = 4'd3;
    for (int k = 1; k <= 8; k++) do_tick();
    checks++;
    if (vis !== 10'h007) begin
      failures++;
      $display("FAIL stop_setup vis=%h required 007", vis);
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if (vis !== 10'h000 || active_count !== 4'd0 || wave_clear !== 1'b0) begin
      failures++;
      $display("FAIL stop_clear vis=%h count=%0d wc=%b required 000/0/0", vis, active_count, wave_clear);
    end
    kill = 10'h3FF; do_tick(); kill = '0;
    checks++;
    if (vis !== 10'h000 || wave_clear !== 1'b0 || spawn_pulse !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_stop vis=%h wc=%b sp=%b required 000/0/0", vis, wave_clear, spawn_pulse);
    end
  endtask

  task automatic test_pause();
    logic [9:0] e;
    target_amount = 4'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 6; k++) do_tick();
    checks++;
    if (vis !== 10'h003) begin
      failures++;
      $display("FAIL pause_setup vis=%h required 003", vis);
    end
    pause = 1'b1; step();
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) kill = 10'b1;
      do_tick();
      kill = '0;
      e = (k < 4) ? 10'h003 : 10'h002;
      checks++;
      if (vis !== e || spawn_pulse !== 1'b0 || wave_clear !== 1'b0) begin
        failures++;
        $display("FAIL paused tick=%0d vis=%h sp=%b wc=%b required %h/0/0", k, vis, spawn_pulse, wave_clear, e);
      end
    end
    pause = 1'b0; step();
    for (int k = 1; k <= 7; k++) begin
      do_tick();
      e = (k < 3) ? 10'h002 : (k < 7) ? 10'h003 : 10'h007;
      checks++;
      if (vis !== e || spawn_pulse !== (k == 3 || k == 7)) begin
        failures++;
        $display("FAIL resume tick=%0d vis=%h sp=%b required %h", k, vis, spawn_pulse, e);
      end
    end
  endtask

  task automatic test_back_to_back_kill();
    kill = 10'b0000000101; step(); kill = '0;
    checks++;
    if (vis !== 10'h002 || active_count !== 4'd1 || wave_clear !== 1'b0) begin
      failures++;
      $display("FAIL multi_kill vis=%h count=%0d wc=%b required 002/1/0", vis, active_count, wave_clear);
    end
  endtask

  task automatic test_async_reset();
    resetn = 1'b0;
    #2;
    checks++;
    if (vis !== 10'h000 || active_count !== 4'd0 || spawn_pulse !== 1'b0 || wave_clear !== 1'b0) begin
      failures++;
      $display("FAIL async_reset vis=%h count=%0d sp=%b wc=%b required all zero", vis, active_count, spawn_pulse, wave_clear);
    end
    step();
    resetn = 1'b1;
    step();
    do_tick();
    checks++;
    if (vis !== 10'h000) begin
      failures++;
      $display("FAIL reset_to_idle vis=%h required 000", vis);
    end
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    do_tick();
    checks++;
    if (vis !== 10'h000) begin
      failures++;
      $display("FAIL stop_over_start vis=%h required 000", vis);
    end
    start = 1'b1; step(); start = 1'b0;
    do_tick();
    checks++;
    if (vis !== 10'h001 || spawn_pulse !== 1'b1) begin
      failures++;
      $display("FAIL restart_first_tick vis=%h sp=%b required 001/1", vis, spawn_pulse);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ramp();
    test_kill_refill();
    test_clamp();
    test_wave_clear();
    test_pause();
    test_back_to_back_kill();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
